ccff_chain_loader: RTL and testbench
====================================

// Module: ccff_chain_loader
// PURPOSE
//  Upstream driver of the configuration-chain head of a logic tile (frac_logic: frac_lut4 + output-mux mem).
//  - Accepts parallel config words over valid/ready and shifts them serially into ccff_head.
//  - Advances the chain only through a per-cycle shift enable, which drives the chain's prog_clk gate.
//  - Recirculates the chain once to verify its contents with a CRC-8 signature; contents are left intact.
// PARAMETERS
//  CHAIN_LEN  20  number of flops in the downstream chain (ccff_head..ccff_tail)
//  WORD_W     8   config word width; words shifted MSB first
//  CLR_CYC    4   cycles chain_pReset is held high before loading
// PORTS
//  prog_clk       in   1       single clock
//  pReset_n       in   1       reset, asynchronous, active-low
//  start          in   1       pulse: begin configuration session (ignored while busy)
//  cfg_data       in   WORD_W  config word
//  cfg_valid      in   1       cfg_data valid
//  cfg_ready      out  1       word accepted when cfg_valid & cfg_ready
//  ccff_head      out  1       serial bit into chain
//  ccff_tail      in   1       serial bit out of chain (Q of last chain flop)
//  ccff_shift_en  out  1       chain shifts on the prog_clk edge ending a cycle with this high
//  chain_pReset   out  1       active-high reset to chain memories
//  busy           out  1       high in any state except IDLE
//  done           out  1       one-cycle pulse at session end
//  pass           out  1       verify result; valid from done until next accepted start
// BEHAVIOUR
//  Interface: one clock; reset is asynchronous and active-low.
//  Reset values: every output 0; state IDLE; counters 0; both CRCs 0x00.
//  FSM: IDLE -> CLEAR -> LOAD -> VERIFY -> FINISH -> IDLE.
//  - IDLE: start=1 -> CLEAR. Clears pass, bit counter, word register, crc_in and crc_out.
//  - CLEAR: chain_pReset=1, shift_en=0 for exactly CLR_CYC cycles, then LOAD.
//  - LOAD:
//    - Word register holds bits_left (0..WORD_W).
//    - cfg_ready=1 when bits_left<=1 and words_accepted < ceil(CHAIN_LEN/WORD_W). A word may load
//      in the same cycle its predecessor's last bit shifts, so back-to-back words give one bit/cycle.
//    - Accepted word's MSB is presented on ccff_head the cycle after acceptance.
//    - shift_en=1 only while bits_left>0. With cfg_valid low and the register empty: shift_en=0, stall.
//    - Each shifted bit updates crc_in and increments bit_cnt.
//    - When bit_cnt reaches CHAIN_LEN: go to VERIFY; unshifted low-order bits of the last word discarded.
//    - First bit shifted ends at the tail-side flop.
//  - VERIFY: exactly CHAIN_LEN cycles.
//    - shift_en=1, ccff_head=ccff_tail (combinational recirculate).
//    - crc_out updated with ccff_tail each cycle.
//    - Tail emits bits in load order; chain content is restored afterwards.
//  - FINISH: one cycle; done=1; pass<=(crc_out==crc_in); shift_en=0; then IDLE.
//  CRC-8: poly 0x07, serial, MSB-side. fb=crc[7]^bit; crc={crc[6:0],1'b0}^(fb?8'h07:8'h00).
//  Unstalled latency, start to done: 1+CLR_CYC+CHAIN_LEN+CHAIN_LEN+1 cycles.
//  ccff_head=0 whenever shift_en=0. cfg_ready=0 outside LOAD.
//  Boundaries:
//  - start while busy: ignored.
//  - cfg_valid during IDLE/CLEAR: not accepted.
//  - CHAIN_LEN multiple of WORD_W: no bits discarded, no extra ready.
//  - pReset_n low mid-session: immediate return to reset values; chain content undefined, and a
//    new start performs a full session.
// TESTING
//  1 CHAIN_LEN=20/WORD_W=8: start; words 0xA5,0x3C,0xF0 back-to-back -> 4 cycles chain_pReset=1;
//    20 contiguous shift_en cycles; head=1010_0101_0011_1100_1111; 0000 dropped; 20 VERIFY cycles;
//    done at cycle 46, pass=1; chain model unchanged.
//  2 Same words, cfg_valid low 5 cycles between words 1 and 2 -> shift_en low exactly those 5 cycles;
//    done at cycle 51, pass=1.
//  3 Bench inverts one ccff_tail bit in VERIFY cycle 7 -> pass=0 at done.
//  4 start pulsed during LOAD, and cfg_valid high during CLEAR -> no restart; cfg_ready=0 in CLEAR;
//    result identical to test 1.
//  5 pReset_n low at LOAD bit 9 -> all outputs 0 asynchronously; a following full session gives pass=1.
//  6 CHAIN_LEN=16/WORD_W=8, words 0xFF,0x00 then cfg_valid held high -> exactly 2 accepts;
//    cfg_ready never rises a third time; pass=1.

Source files
------------

// File: rtl/ccff_chain_loader.sv
// Serial loader for a tile configuration chain: shifts parallel words into ccff_head,
// then recirculates the chain once and compares CRC-8 signatures of loaded vs read-back bits.
module ccff_chain_loader #(
  parameter int unsigned CHAIN_LEN = 20,
  parameter int unsigned WORD_W    = 8,
  parameter int unsigned CLR_CYC   = 4
) (
  input  logic              prog_clk,
  input  logic              pReset_n,
  input  logic              start,
  input  logic [WORD_W-1:0] cfg_data,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic              ccff_head,
  input  logic              ccff_tail,
  output logic              ccff_shift_en,
  output logic              chain_pReset,
  output logic              busy,
  output logic              done,
  output logic              pass
);

  localparam int unsigned NWORDS = (CHAIN_LEN + WORD_W - 1) / WORD_W;
  localparam int unsigned BCW    = $clog2(CHAIN_LEN + 1);
  localparam int unsigned BLW    = $clog2(WORD_W + 1);
  localparam int unsigned WCW    = $clog2(NWORDS + 1);
  localparam int unsigned CCW    = (CLR_CYC > 1) ? $clog2(CLR_CYC) : 1;

  localparam logic [BCW-1:0] LAST_BIT  = BCW'(CHAIN_LEN - 1);
  localparam logic [BLW-1:0] FULL_WORD = BLW'(WORD_W);
  localparam logic [WCW-1:0] MAX_WORDS = WCW'(NWORDS);
  localparam logic [CCW-1:0] LAST_CLR  = CCW'(CLR_CYC - 1);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StClear  = 3'd1;
  localparam logic [2:0] StLoad   = 3'd2;
  localparam logic [2:0] StVerify = 3'd3;
  localparam logic [2:0] StFinish = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [CCW-1:0]    clr_cnt_q, clr_cnt_d;
  logic [BCW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [BLW-1:0]    bits_left_q, bits_left_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic [WCW-1:0]    words_q, words_d;
  logic [7:0]        crc_in_q, crc_in_d;
  logic [7:0]        crc_out_q, crc_out_d;
  logic              pass_q, pass_d;
  logic              crc_ok;

  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic b);
    logic fb;
    fb = crc[7] ^ b;
    return {crc[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
  endfunction

  assign crc_ok = (crc_out_q == crc_in_q);

  always_comb begin
    cfg_ready     = 1'b0;
    ccff_shift_en = 1'b0;
    ccff_head     = 1'b0;
    chain_pReset  = 1'b0;
    done          = 1'b0;
    busy          = (state_q != StIdle);
    pass          = pass_q;
    case (state_q)
      StClear: chain_pReset = 1'b1;
      StLoad: begin
        ccff_shift_en = (bits_left_q != '0);
        ccff_head     = ccff_shift_en & word_q[WORD_W-1];
        // Ready on the last bit too, so the next word lands with no bubble.
        cfg_ready     = (bits_left_q <= BLW'(1)) && (words_q < MAX_WORDS);
      end
      StVerify: begin
        ccff_shift_en = 1'b1;
        ccff_head     = ccff_tail;
      end
      StFinish: begin
        done = 1'b1;
        pass = crc_ok;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    clr_cnt_d   = clr_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    bits_left_d = bits_left_q;
    word_d      = word_q;
    words_d     = words_q;
    crc_in_d    = crc_in_q;
    crc_out_d   = crc_out_q;
    pass_d      = pass_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          state_d     = StClear;
          clr_cnt_d   = '0;
          bit_cnt_d   = '0;
          bits_left_d = '0;
          word_d      = '0;
          words_d     = '0;
          crc_in_d    = '0;
          crc_out_d   = '0;
          pass_d      = 1'b0;
        end
      end
      StClear: begin
        if (clr_cnt_q == LAST_CLR) state_d = StLoad;
        else                       clr_cnt_d = clr_cnt_q + CCW'(1);
      end
      StLoad: begin
        if (ccff_shift_en) begin
          crc_in_d    = crc8_step(crc_in_q, word_q[WORD_W-1]);
          bit_cnt_d   = bit_cnt_q + BCW'(1);
          word_d      = word_q << 1;
          bits_left_d = bits_left_q - BLW'(1);
        end
        if (cfg_valid && cfg_ready) begin
          word_d      = cfg_data;
          bits_left_d = FULL_WORD;
          words_d     = words_q + WCW'(1);
        end
        // Chain full: any unshifted tail of the last word is dropped.
        if (ccff_shift_en && (bit_cnt_q == LAST_BIT)) begin
          state_d     = StVerify;
          bit_cnt_d   = '0;
          bits_left_d = '0;
          word_d      = '0;
        end
      end
      StVerify: begin
        crc_out_d = crc8_step(crc_out_q, ccff_tail);
        bit_cnt_d = bit_cnt_q + BCW'(1);
        if (bit_cnt_q == LAST_BIT) begin
          state_d   = StFinish;
          bit_cnt_d = '0;
        end
      end
      StFinish: begin
        pass_d  = crc_ok;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge prog_clk or negedge pReset_n) begin
    if (!pReset_n) begin
      state_q     <= StIdle;
      clr_cnt_q   <= '0;
      bit_cnt_q   <= '0;
      bits_left_q <= '0;
      word_q      <= '0;
      words_q     <= '0;
      crc_in_q    <= 8'h00;
      crc_out_q   <= 8'h00;
      pass_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      clr_cnt_q   <= clr_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      bits_left_q <= bits_left_d;
      word_q      <= word_d;
      words_q     <= words_d;
      crc_in_q    <= crc_in_d;
      crc_out_q   <= crc_out_d;
      pass_q      <= pass_d;
    end
  end

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Directed bench for ccff_chain_loader: a 20-flop and a 16-flop chain model driven by two instances.
module tb_ccff_chain_loader;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start20 = 1'b0, start16 = 1'b0;
  logic [7:0] cfg_data = 8'h00;
  logic       cfg_valid = 1'b0;
  logic       inj = 1'b0;

  logic ready20, head20, shen20, prst20, busy20, done20, pass20, tail20;
  logic ready16, head16, shen16, prst16, busy16, done16, pass16, tail16;
  logic [19:0] ch20 = '0;
  logic [15:0] ch16 = '0;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  ccff_chain_loader #(.CHAIN_LEN(20), .WORD_W(8), .CLR_CYC(4)) dut (
    .prog_clk(clk), .pReset_n(rst_n), .start(start20), .cfg_data(cfg_data),
    .cfg_valid(cfg_valid), .cfg_ready(ready20), .ccff_head(head20), .ccff_tail(tail20),
    .ccff_shift_en(shen20), .chain_pReset(prst20), .busy(busy20), .done(done20), .pass(pass20)
  );

  ccff_chain_loader #(.CHAIN_LEN(16), .WORD_W(8), .CLR_CYC(4)) dut16 (
    .prog_clk(clk), .pReset_n(rst_n), .start(start16), .cfg_data(cfg_data),
    .cfg_valid(cfg_valid), .cfg_ready(ready16), .ccff_head(head16), .ccff_tail(tail16),
    .ccff_shift_en(shen16), .chain_pReset(prst16), .busy(busy16), .done(done16), .pass(pass16)
  );

  // Chain models: bit 0 is the head-side flop, the MSB drives ccff_tail.
  assign tail20 = ch20[19] ^ inj;
  assign tail16 = ch16[15] ^ inj;

  always @(posedge clk) begin
    if (prst20)      ch20 <= '0;
    else if (shen20) ch20 <= {ch20[18:0], head20};
    if (prst16)      ch16 <= '0;
    else if (shen16) ch16 <= {ch16[14:0], head16};
  end

  typedef struct {
    string       name;
    bit          sel;
    logic [7:0]  w0, w1, w2;
    int          nwords, gap, inj_at;
    bit          disturb;
    int          exp_done;
    bit          exp_pass;
    int          exp_stall;
    logic [19:0] exp_head, exp_chain;
    int          exp_acc, exp_ready_hi;
  } vec_t;

  vec_t vecs[5];

  function automatic vec_t mk(input string nm, input bit sel, input logic [7:0] w0, w1, w2,
                              input int gap, input int inj_at, input bit disturb,
                              input int exp_done, input bit exp_pass, input int exp_stall,
                              input logic [19:0] exp_head, input logic [19:0] exp_chain,
                              input int exp_acc, input int exp_ready_hi);
    vec_t v;
    v.name = nm; v.sel = sel; v.w0 = w0; v.w1 = w1; v.w2 = w2; v.nwords = 3;
    v.gap = gap; v.inj_at = inj_at; v.disturb = disturb; v.exp_done = exp_done;
    v.exp_pass = exp_pass; v.exp_stall = exp_stall; v.exp_head = exp_head;
    v.exp_chain = exp_chain; v.exp_acc = exp_acc; v.exp_ready_hi = exp_ready_hi;
    return v;
  endfunction

  task automatic check(input string nm, input string what, input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s.%s: got 0x%0h, expected 0x%0h", nm, what, got, exp);
    end
  endtask

  // Observations of one session
  int          o_done_cyc, o_ndone, o_preset_cnt, o_preset_first, o_stall, o_shifts;
  int          o_acc, o_ready_hi, o_ready_bad, o_head_bad, o_busy_bad;
  logic        o_pass_done, o_pass_after;
  logic [19:0] o_head_bits;

  task automatic run_session(input vec_t v);
    int L, wi, gap_left;
    bit seen_done;
    logic [7:0] words [3];
    logic r, h, s, p, b, d, ps;
    L = v.sel ? 16 : 20;
    words[0] = v.w0; words[1] = v.w1; words[2] = v.w2;
    wi = 0; gap_left = v.gap; seen_done = 0;
    o_done_cyc = -1; o_ndone = 0; o_preset_cnt = 0; o_preset_first = -1; o_stall = 0;
    o_shifts = 0; o_acc = 0; o_ready_hi = 0; o_ready_bad = 0; o_head_bad = 0; o_busy_bad = 0;
    o_pass_done = 1'bx; o_pass_after = 1'bx; o_head_bits = '0;
    for (int cyc = 0; cyc < 150; cyc++) begin
      @(negedge clk);
      start20 = !v.sel && (cyc == 0 || (v.disturb && cyc == 10));
      start16 =  v.sel && (cyc == 0 || (v.disturb && cyc == 10));
      inj = (v.inj_at >= 0) && (o_shifts == L + v.inj_at);
      cfg_valid = 1'b0;
      cfg_data = 8'h00;
      if (wi < v.nwords && cyc >= (v.disturb ? 0 : 5) && !(wi == 1 && gap_left > 0)) begin
        cfg_valid = 1'b1;
        cfg_data = words[wi];
      end
      #1;
      r = v.sel ? ready16 : ready20;  h = v.sel ? head16 : head20;
      s = v.sel ? shen16  : shen20;   p = v.sel ? prst16 : prst20;
      b = v.sel ? busy16  : busy20;   d = v.sel ? done16 : done20;
      ps = v.sel ? pass16 : pass20;
      if (seen_done) begin
        o_pass_after = ps;
        if (b !== 1'b0) o_busy_bad++;
        break;
      end
      if (p) begin
        o_preset_cnt++;
        if (o_preset_first < 0) o_preset_first = cyc;
        if (r) o_ready_bad++;
      end
      if (r) o_ready_hi++;
      if (wi == 1 && gap_left > 0 && r) gap_left--;
      if (cfg_valid && r) begin
        wi++;
        o_acc++;
      end
      if (!s && h) o_head_bad++;
      if (b !== (cyc >= 1 && cyc <= v.exp_done)) o_busy_bad++;
      if (s) begin
        if (o_shifts < L) o_head_bits = {o_head_bits[18:0], h};
        o_shifts++;
      end else if (o_shifts > 0 && o_shifts < L) begin
        o_stall++;
      end
      if (d) begin
        o_ndone++;
        o_done_cyc = cyc;
        o_pass_done = ps;
        seen_done = 1;
      end
    end
    start20 = 1'b0; start16 = 1'b0; cfg_valid = 1'b0; cfg_data = 8'h00; inj = 1'b0;
  endtask

  task automatic run_and_check(input vec_t v);
    int L;
    logic [19:0] chain;
    L = v.sel ? 16 : 20;
    run_session(v);
    chain = v.sel ? {4'b0, ch16} : ch20;
    check(v.name, "done_cycle", o_done_cyc, v.exp_done);
    check(v.name, "done_pulses", o_ndone, 1);
    check(v.name, "pass_at_done", {31'b0, o_pass_done}, {31'b0, v.exp_pass});
    check(v.name, "pass_held", {31'b0, o_pass_after}, {31'b0, v.exp_pass});
    check(v.name, "preset_cycles", o_preset_cnt, 4);
    check(v.name, "preset_first", o_preset_first, 1);
    check(v.name, "head_bits", {12'b0, o_head_bits}, {12'b0, v.exp_head});
    check(v.name, "load_stalls", o_stall, v.exp_stall);
    check(v.name, "total_shifts", o_shifts, 2 * L);
    check(v.name, "chain_after", {12'b0, chain}, {12'b0, v.exp_chain});
    check(v.name, "accepts", o_acc, v.exp_acc);
    check(v.name, "ready_cycles", o_ready_hi, v.exp_ready_hi);
    check(v.name, "ready_in_clear", o_ready_bad, 0);
    check(v.name, "head_when_idle", o_head_bad, 0);
    check(v.name, "busy_profile", o_busy_bad, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t v;
    bit hit;
    int sh;
    vecs[0] = mk("b2b",     0, 8'hA5, 8'h3C, 8'hF0, 0, -1, 0, 46, 1, 0,
                 20'hA53CF, 20'hA53CF, 3, 3);
    vecs[1] = mk("gap5",    0, 8'hA5, 8'h3C, 8'hF0, 5, -1, 0, 51, 1, 5,
                 20'hA53CF, 20'hA53CF, 3, 8);
    vecs[2] = mk("inject",  0, 8'hA5, 8'h3C, 8'hF0, 0,  7, 0, 46, 0, 0,
                 20'hA53CF, 20'hA43CF, 3, 3);
    vecs[3] = mk("disturb", 0, 8'hA5, 8'h3C, 8'hF0, 0, -1, 1, 46, 1, 0,
                 20'hA53CF, 20'hA53CF, 3, 3);
    vecs[4] = mk("len16",   1, 8'hFF, 8'h00, 8'hAA, 0, -1, 0, 38, 1, 0,
                 20'h0FF00, 20'h0FF00, 2, 2);

    #1;
    check("reset", "outs20", {25'b0, ready20, head20, shen20, prst20, busy20, done20, pass20}, 0);
    check("reset", "outs16", {25'b0, ready16, head16, shen16, prst16, busy16, done16, pass16}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 5; i++) run_and_check(vecs[i]);

    // Asynchronous reset in the middle of the load phase
    sh = 0;
    hit = 0;
    for (int c = 0; c < 60 && !hit; c++) begin
      @(negedge clk);
      start20 = (c == 0);
      cfg_valid = (c >= 5);
      cfg_data = 8'hA5;
      #1;
      if (shen20) sh++;
      if (sh == 9) hit = 1;
    end
    check("midreset", "reached_bit9", {31'b0, hit}, 1);
    check("midreset", "shifting_before", {31'b0, shen20}, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("midreset", "outs20", {25'b0, ready20, head20, shen20, prst20, busy20, done20, pass20}, 0);
    start20 = 1'b0;
    cfg_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    v = vecs[0];
    v.name = "after_reset";
    run_and_check(v);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
